array_skew_feeder: RTL

- Input-side counterpart of the systolic array's output path: accepts row vectors of ARRAY_SIZE FP32 lanes from the SRAM read stream and drives the array's west edge.
- Applies diagonal skew: lane i is delayed i cycles relative to lane 0. The output side de-skews; this block skews.
- No numeric conversion. Each FP32 word is passed bit-exact, zero-filled where no valid data is present.
- One job = one `start`, N accepted rows terminated by `in_last`, then a flush and a `done` pulse.

---
 rtl/tpu_feed_pkg.sv | 23 ++
 rtl/skew_delay_line.sv | 34 +++
 rtl/array_skew_feeder.sv | 105 ++++++++++
 3 files changed

// File: rtl/tpu_feed_pkg.sv
// Shared types and helpers for the systolic-array west-edge feeder.
// Holds the feeder state encoding, flush-counter sizing and lane slicing.
package tpu_feed_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } feed_state_e;

  localparam int DEFAULT_ARRAY_SIZE = 8;
  localparam int FLUSH_CNT_W        = $clog2(DEFAULT_ARRAY_SIZE);

  // Flush counter must hold ARRAY_SIZE-1.
  function automatic int flush_cnt_width(input int lanes);
    return $clog2(lanes);
  endfunction

  function automatic int lane_lsb(input int lane, input int data_width);
    return lane * data_width;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Reset-clearable shift register carrying {valid, data}.
// One instance per lane; DEPTH sets that lane's total latency.
module skew_delay_line #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  d_valid,
  input  logic [DATA_WIDTH-1:0] d_data,
  output logic                  q_valid,
  output logic [DATA_WIDTH-1:0] q_data
);

  logic [DATA_WIDTH:0] pipe_r [DEPTH];

  // Shift stage contents forward every cycle; the array never stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        pipe_r[k] <= {(DATA_WIDTH + 1){1'b0}};
      end
    end else begin
      pipe_r[0] <= {d_valid, d_data};
      for (int k = 1; k < DEPTH; k++) begin
        pipe_r[k] <= pipe_r[k-1];
      end
    end
  end

  assign q_valid = pipe_r[DEPTH-1][DATA_WIDTH];
  assign q_data  = pipe_r[DEPTH-1][DATA_WIDTH-1:0];

endmodule

// File: rtl/array_skew_feeder.sv
// West-edge feeder: accepts row vectors and drives them diagonally skewed
// into the systolic array, lane i delayed i cycles behind lane 0.
module array_skew_feeder
  import tpu_feed_pkg::*;
#(
  parameter int ARRAY_SIZE    = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int ROW_CNT_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_data,
  input  logic                             in_last,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] feed_data,
  output logic [ARRAY_SIZE-1:0]            feed_valid,
  output logic                             busy,
  output logic                             done,
  output logic [ROW_CNT_WIDTH-1:0]         row_count
);

  localparam int FCW = flush_cnt_width(ARRAY_SIZE);

  feed_state_e              state_r;
  logic [FCW-1:0]           flush_cnt_r;
  logic                     done_r;
  logic [ROW_CNT_WIDTH-1:0] row_count_r;
  logic                     accept_s;

  assign in_ready  = (state_r == STREAM);
  assign accept_s  = in_valid & in_ready;
  assign busy      = (state_r != IDLE);
  assign done      = done_r;
  assign row_count = row_count_r;

  // Job sequencing: start, row acceptance, flush countdown and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      flush_cnt_r <= {FCW{1'b0}};
      done_r      <= 1'b0;
      row_count_r <= {ROW_CNT_WIDTH{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r     <= STREAM;
            row_count_r <= {ROW_CNT_WIDTH{1'b0}};
          end else begin
            state_r <= IDLE;
          end
        end
        STREAM: begin
          if (accept_s) begin
            row_count_r <= row_count_r + {{(ROW_CNT_WIDTH-1){1'b0}}, 1'b1};
            if (in_last) begin
              state_r     <= FLUSH;
              flush_cnt_r <= FCW'(ARRAY_SIZE - 1);
            end else begin
              state_r <= STREAM;
            end
          end else begin
            state_r <= STREAM;
          end
        end
        FLUSH: begin
          // Counter covers the time the last row needs to reach the far lane.
          if (flush_cnt_r == {FCW{1'b0}}) begin
            state_r <= IDLE;
            done_r  <= 1'b1;
          end else begin
            flush_cnt_r <= flush_cnt_r - {{(FCW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
    logic [DATA_WIDTH-1:0] lane_s;

    // Non-accepted slots enter as zero so invalid lanes always read 0.
    assign lane_s = accept_s ? in_data[lane_lsb(gi, DATA_WIDTH) +: DATA_WIDTH]
                             : {DATA_WIDTH{1'b0}};

    skew_delay_line #(
      .DEPTH      (gi + 1),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_delay (
      .clk     (clk),
      .rst_n   (rst_n),
      .d_valid (accept_s),
      .d_data  (lane_s),
      .q_valid (feed_valid[gi]),
      .q_data  (feed_data[lane_lsb(gi, DATA_WIDTH) +: DATA_WIDTH])
    );
  end

endmodule
